// File: rtl/sub12_seq_ctrl.sv
// Multi-cycle subtract sequencer: M - S - Bin through one shared 4-bit slice, LSB nibble first.
// Latency NIB+1 edges from acceptance to rsp_valid; DONE holds until rsp_ready, no request accepted meanwhile.
module sub12_seq_ctrl #(
    parameter  int NIB = 3,
    localparam int W   = 4 * NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] op_m,
    input  logic [W-1:0] op_s,
    input  logic         op_bin,
    input  logic         op_cmp,
    output logic [3:0]   slc_m,
    output logic [3:0]   slc_s,
    output logic         slc_bin,
    input  logic [3:0]   slc_d,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         zero,
    output logic         ovf
);

    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    s_q, s_d;
    logic            bin_q, bin_d;
    logic            cmp_q, cmp_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            brw_q, brw_d;
    logic [W-1:0]    res_q, res_d;

    logic [3:0]      nib_m;
    logic [3:0]      nib_s;
    logic            nib_bin;
    logic            nib_bout;

    // Current nibble operands; only meaningful while sequencing.
    always_comb begin
        nib_m    = m_q[{idx_q, 2'b00} +: 4];
        nib_s    = s_q[{idx_q, 2'b00} +: 4];
        nib_bin  = (idx_q == '0) ? bin_q : brw_q;
        // The slice has no borrow-out, so the chain is rebuilt here at 5-bit width.
        nib_bout = ({1'b0, nib_m} < ({1'b0, nib_s} + {4'b0000, nib_bin}));
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        s_d       = s_q;
        bin_d     = bin_q;
        cmp_d     = cmp_q;
        idx_d     = idx_q;
        brw_d     = brw_q;
        res_d     = res_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        slc_m     = 4'h0;
        slc_s     = 4'h0;
        slc_bin   = 1'b0;
        diff      = '0;
        borrow    = 1'b0;
        zero      = 1'b0;
        ovf       = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    m_d     = op_m;
                    s_d     = op_s;
                    bin_d   = op_bin;
                    cmp_d   = op_cmp;
                    idx_d   = '0;
                    brw_d   = 1'b0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                slc_m   = nib_m;
                slc_s   = nib_s;
                slc_bin = nib_bin;
                res_d[{idx_q, 2'b00} +: 4] = slc_d;
                brw_d   = nib_bout;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                diff      = cmp_q ? '0 : res_q;
                borrow    = brw_q;
                zero      = (res_q == '0);
                ovf       = (m_q[W-1] ^ s_q[W-1]) & (m_q[W-1] ^ res_q[W-1]);
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            s_q     <= '0;
            bin_q   <= 1'b0;
            cmp_q   <= 1'b0;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            bin_q   <= bin_d;
            cmp_q   <= cmp_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_sub12_seq_ctrl.sv
// Directed bench for sub12_seq_ctrl with a behavioural 4-bit subtractor slice attached.
module tb_sub12_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] op_m;
    logic [11:0] op_s;
    logic        op_bin;
    logic        op_cmp;
    logic [3:0]  slc_m;
    logic [3:0]  slc_s;
    logic        slc_bin;
    logic [3:0]  slc_d;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] cap_m [3];
    logic [3:0] cap_s [3];
    logic       cap_b [3];

    sub12_seq_ctrl #(.NIB(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_m      (op_m),
        .op_s      (op_s),
        .op_bin    (op_bin),
        .op_cmp    (op_cmp),
        .slc_m     (slc_m),
        .slc_s     (slc_s),
        .slc_bin   (slc_bin),
        .slc_d     (slc_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    // Behavioural slice: 4-bit difference, wraps modulo 16.
    assign slc_d = slc_m - slc_s - {3'b000, slc_bin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, capture slice inputs per nibble, check response timing and flags.
    task automatic run_op(input string tag, input logic [11:0] m, input logic [11:0] s,
                          input logic bin, input logic cmp,
                          input logic [11:0] e_diff, input logic e_brw,
                          input logic e_zero, input logic e_ovf);
        @(negedge clk);
        chk({tag, ".req_ready"}, {15'd0, req_ready}, 16'd1);
        req_valid = 1'b1;
        op_m      = m;
        op_s      = s;
        op_bin    = bin;
        op_cmp    = cmp;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            cap_m[k]  = slc_m;
            cap_s[k]  = slc_s;
            cap_b[k]  = slc_bin;
            if (k == 2) chk({tag, ".early_rsp"}, {15'd0, rsp_valid}, 16'd0);
        end
        @(negedge clk);
        chk({tag, ".rsp_valid"}, {15'd0, rsp_valid}, 16'd1);
        chk({tag, ".diff"},      {4'd0, diff},       {4'd0, e_diff});
        chk({tag, ".borrow"},    {15'd0, borrow},    {15'd0, e_brw});
        chk({tag, ".zero"},      {15'd0, zero},      {15'd0, e_zero});
        chk({tag, ".ovf"},       {15'd0, ovf},       {15'd0, e_ovf});
        chk({tag, ".slc_idle"},  {11'd0, slc_m, slc_bin}, 16'd0);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"},  {15'd0, rsp_valid}, 16'd0);
        chk({tag, ".req_back"},  {15'd0, req_ready}, 16'd1);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        op_m      = '0;
        op_s      = '0;
        op_bin    = 1'b0;
        op_cmp    = 1'b0;
        rsp_ready = 1'b0;

        // Reset state
        #12;
        chk("rst.req_ready", {15'd0, req_ready}, 16'd1);
        chk("rst.rsp_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rst.outs",      {1'd0, diff, borrow, zero, ovf}, 16'd0);
        chk("rst.slc",       {7'd0, slc_m, slc_s, slc_bin}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 2: nibble sequencing and latency
        run_op("t2", 12'h123, 12'h023, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0);
        chk("t2.nib0", {7'd0, cap_m[0], cap_s[0], cap_b[0]}, {7'd0, 4'h3, 4'h3, 1'b0});
        chk("t2.nib1", {7'd0, cap_m[1], cap_s[1], cap_b[1]}, {7'd0, 4'h2, 4'h2, 1'b0});
        chk("t2.nib2", {7'd0, cap_m[2], cap_s[2], cap_b[2]}, {7'd0, 4'h1, 4'h0, 1'b0});
        finish_rsp("t2");

        // Test 3: borrow ripples through every nibble
        run_op("t3", 12'h000, 12'h001, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0);
        chk("t3.bin_chain", {13'd0, cap_b[0], cap_b[1], cap_b[2]}, 16'b011);
        finish_rsp("t3");

        // Test 4: signed overflow, and initial borrow-in
        run_op("t4a", 12'h800, 12'h001, 1'b0, 1'b0, 12'h7FF, 1'b0, 1'b0, 1'b1);
        finish_rsp("t4a");
        run_op("t4b", 12'h005, 12'h005, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0);
        chk("t4b.bin0", {15'd0, cap_b[0]}, 16'd1);
        finish_rsp("t4b");
        run_op("t4c", 12'h7FF, 12'hFFF, 1'b0, 1'b0, 12'h800, 1'b1, 1'b0, 1'b1);
        finish_rsp("t4c");

        // Test 5: compare mode forces diff to zero but keeps flags
        run_op("t5a", 12'h555, 12'h555, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0);
        finish_rsp("t5a");
        run_op("t5b", 12'h554, 12'h555, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
        finish_rsp("t5b");

        // Test 6: backpressure with a second request waiting
        @(negedge clk);
        req_valid = 1'b1;
        op_m      = 12'h0F0;
        op_s      = 12'h00F;
        op_bin    = 1'b0;
        op_cmp    = 1'b0;
        @(negedge clk);
        op_m = 12'h456;
        op_s = 12'h123;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6.diff_a", {4'd0, diff}, 16'h00E1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6.hold", {1'd0, rsp_valid, req_ready, diff, borrow, zero, ovf},
                {1'd0, 1'b1, 1'b0, 12'h0E1, 1'b0, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t6.idle", {14'd0, rsp_valid, req_ready}, 16'b01);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t6.accept_b", {7'd0, req_ready, slc_m, slc_s}, {7'd0, 1'b0, 4'h6, 4'h3});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6.diff_b", {1'd0, rsp_valid, diff, borrow, zero, ovf},
            {1'd0, 1'b1, 12'h333, 1'b0, 1'b0, 1'b0});
        finish_rsp("t6");

        // Test 1: asynchronous reset during NIB(1) aborts the operation
        @(negedge clk);
        req_valid = 1'b1;
        op_m      = 12'h321;
        op_s      = 12'h123;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1.rst_ready", {14'd0, rsp_valid, req_ready}, 16'b01);
        chk("t1.rst_slc",   {7'd0, slc_m, slc_s, slc_bin}, 16'd0);
        chk("t1.rst_outs",  {1'd0, diff, borrow, zero, ovf}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        rsp_ready = 1'b0;
        chk("t1.no_rsp", {15'd0, seen}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
